// File: rtl/gf128_inv_if.sv
// Operand/result handshake bundle for gf128_inv.
// Operand in on in_*, result out on out_*.
interface gf128_inv_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] x;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] z;
  logic         zero_in;

  modport master (
    output in_valid, x, out_ready,
    input  in_ready, out_valid, z, zero_in
  );

  modport slave (
    input  in_valid, x, out_ready,
    output in_ready, out_valid, z, zero_in
  );
endinterface

// File: rtl/gf128_inv.sv
// GF(2^128) inverter, GCM field: z = x^(2^128-2).
// Iterates s=s^2, r=r*s over 127 steps on gcm_mult.
module gcm_mult (
  input  logic [127:0] a,
  input  logic [127:0] b,
  output logic [127:0] p
);
  logic [127:0] v;

  always_comb begin
    p = '0;
    v = a;
    for (int i = 0; i < 128; i++) begin
      if (b[i]) p = p ^ v;
      v = {v[126:0], 1'b0} ^ (v[127] ? 128'h87 : 128'h0);
    end
  end
endmodule

module gf128_inv #(
  parameter int NUM_MULT = 1
) (
  input logic        clk,
  input logic        rst_n,
  gf128_inv_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE, SQR, MUL, DONE
  } state_t;

  state_t       state, state_d;
  logic [127:0] s, r, z_q;
  logic [127:0] sq, rm;
  logic [6:0]   cnt;
  logic         zero_q;
  logic         load, sq_en, mul_en, fin;

  if (NUM_MULT != 1 && NUM_MULT != 2) begin : g_bad
    $error("gf128_inv: NUM_MULT must be 1 or 2");
  end

  if (NUM_MULT == 2) begin : g_two
    gcm_mult u_sq (.a(s), .b(s), .p(sq));
    gcm_mult u_mul (.a(r), .b(sq), .p(rm));
  end else begin : g_one
    // One shared multiplier: squares in SQR, accumulates in MUL
    logic [127:0] mb, p1;
    assign mb = (state == SQR) ? s : r;
    gcm_mult u_m (.a(s), .b(mb), .p(p1));
    assign sq = p1;
    assign rm = p1;
  end

  always_comb begin
    state_d = state;
    load    = 1'b0;
    sq_en   = 1'b0;
    mul_en  = 1'b0;
    fin     = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.in_valid) begin
          load    = 1'b1;
          state_d = (NUM_MULT == 2) ? MUL : SQR;
        end
      end
      SQR: begin
        sq_en   = 1'b1;
        state_d = MUL;
      end
      MUL: begin
        mul_en = 1'b1;
        if (cnt == 7'd127) begin
          fin     = 1'b1;
          state_d = DONE;
        end else begin
          state_d = (NUM_MULT == 2) ? MUL : SQR;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s      <= '0;
      r      <= '0;
      cnt    <= '0;
      z_q    <= '0;
      zero_q <= 1'b0;
    end else begin
      if (load) begin
        s      <= bus.x;
        r      <= 128'h1;
        cnt    <= 7'd1;
        zero_q <= (bus.x == '0);
      end
      if (sq_en) s <= sq;
      if (mul_en) begin
        r <= rm;
        if (NUM_MULT == 2) s <= sq;
        if (fin) z_q <= rm;
        else     cnt <= cnt + 7'd1;
      end
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.z         = z_q;
  assign bus.zero_in   = zero_q;
endmodule

// File: tb/tb_gf128_inv.sv
// Bench for gf128_inv: both NUM_MULT variants against
// a power-based field model plus literal vectors.
module tb_gf128_inv;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         iv [2];
  logic         ordy [2];
  logic [127:0] xv [2];
  logic         ir [2];
  logic         ov [2];
  logic         zo [2];
  logic [127:0] zv [2];

  gf128_inv_if b1 ();
  gf128_inv_if b2 ();

  assign b1.in_valid  = iv[0];
  assign b1.x         = xv[0];
  assign b1.out_ready = ordy[0];
  assign ir[0] = b1.in_ready;
  assign ov[0] = b1.out_valid;
  assign zv[0] = b1.z;
  assign zo[0] = b1.zero_in;

  assign b2.in_valid  = iv[1];
  assign b2.x         = xv[1];
  assign b2.out_ready = ordy[1];
  assign ir[1] = b2.in_ready;
  assign ov[1] = b2.out_valid;
  assign zv[1] = b2.z;
  assign zo[1] = b2.zero_in;

  gf128_inv #(.NUM_MULT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(b1)
  );
  gf128_inv #(.NUM_MULT(2)) u2 (
    .clk(clk), .rst_n(rst_n), .bus(b2)
  );

  localparam logic [127:0] Z2 =
    128'h8000_0000_0000_0000_0000_0000_0000_0043;

  int pass_cnt = 0;
  int tot_cnt  = 0;
  int edge_cnt = 0;
  int lat_exp [2];

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Field model: schoolbook multiply and a generic power
  function automatic logic [127:0] gmul(
    input logic [127:0] a, input logic [127:0] b
  );
    logic [127:0] acc, v;
    acc = '0;
    v = a;
    for (int i = 0; i < 128; i++) begin
      if (b[i]) acc = acc ^ v;
      v = {v[126:0], 1'b0} ^ (v[127] ? 128'h87 : 128'h0);
    end
    return acc;
  endfunction

  function automatic logic [127:0] gpow(
    input logic [127:0] a, input logic [127:0] e
  );
    logic [127:0] res, base;
    res = 128'h1;
    base = a;
    for (int i = 0; i < 128; i++) begin
      if (e[i]) res = gmul(res, base);
      base = gmul(base, base);
    end
    return res;
  endfunction

  function automatic logic [127:0] ginv(input logic [127:0] a);
    logic [127:0] e;
    e = '1;
    e[0] = 1'b0;
    return gpow(a, e);
  endfunction

  task automatic chk(
    input string nm, input logic [127:0] act,
    input logic [127:0] exp
  );
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s got=%h want=%h", nm, act, exp);
  endtask

  task automatic tmo(input string nm);
    tot_cnt++;
    $display("FAIL %s timeout", nm);
  endtask

  // Scoreboard: one outstanding operation per unit
  logic         have [2];
  logic [127:0] ex [2];
  logic [127:0] ez [2];
  logic         ezr [2];
  int           acc_e [2];
  logic         pov [2];

  initial begin
    for (int u = 0; u < 2; u++) begin
      have[u] = 1'b0;
      pov[u] = 1'b0;
    end
    lat_exp[0] = 254;
    lat_exp[1] = 127;
  end

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (!rst_n) begin
        have[u] = 1'b0;
        pov[u] = 1'b0;
      end else begin
        if (ov[u]) begin
          if (!have[u]) begin
            tot_cnt++;
            $display("FAIL spurious_out_valid u%0d", u);
          end else begin
            chk($sformatf("z_u%0d", u), zv[u], ez[u]);
            chk($sformatf("zero_in_u%0d", u),
                {127'd0, zo[u]}, {127'd0, ezr[u]});
            chk($sformatf("in_ready_busy_u%0d", u),
                {127'd0, ir[u]}, 128'd0);
            if (!pov[u]) begin
              chk($sformatf("latency_u%0d", u),
                  128'(edge_cnt - acc_e[u]),
                  128'(lat_exp[u]));
              if (!ezr[u])
                chk($sformatf("x_times_z_u%0d", u),
                    gmul(ex[u], zv[u]), 128'h1);
            end
            if (ordy[u]) have[u] = 1'b0;
          end
        end
        if (iv[u] && ir[u]) begin
          chk($sformatf("no_overlap_u%0d", u),
              {127'd0, have[u]}, 128'd0);
          have[u]  = 1'b1;
          ex[u]    = xv[u];
          ez[u]    = ginv(xv[u]);
          ezr[u]   = (xv[u] == '0);
          acc_e[u] = edge_cnt + 1;
        end
        pov[u] = ov[u];
      end
    end
  end

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic send(input int u, input logic [127:0] xx);
    int n;
    @(posedge clk);
    #1;
    iv[u] = 1'b1;
    xv[u] = xx;
    n = 0;
    @(negedge clk);
    while (!ir[u] && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (!ir[u]) tmo($sformatf("send_u%0d", u));
    @(posedge clk);
    #1;
    iv[u] = 1'b0;
    xv[u] = rnd128();
  endtask

  task automatic wait_ov(input int u);
    int n;
    n = 0;
    @(negedge clk);
    while (!ov[u] && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (!ov[u]) tmo($sformatf("result_u%0d", u));
  endtask

  task automatic wait_done(
    input int u, output logic [127:0] zz, output logic zr
  );
    wait_ov(u);
    zz = zv[u];
    zr = zo[u];
    @(posedge clk);
    #1;
  endtask

  task automatic reset_checks();
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("rst_in_ready_u%0d", u),
          {127'd0, ir[u]}, 128'd1);
      chk($sformatf("rst_out_valid_u%0d", u),
          {127'd0, ov[u]}, 128'd0);
      chk($sformatf("rst_z_u%0d", u), zv[u], 128'd0);
      chk($sformatf("rst_zero_in_u%0d", u),
          {127'd0, zo[u]}, 128'd0);
    end
  endtask

  task automatic directed(input int u);
    logic [127:0] zz;
    logic zr;
    send(u, 128'h1);
    wait_done(u, zz, zr);
    chk($sformatf("dir_x1_z_u%0d", u), zz, 128'h1);
    chk($sformatf("dir_x1_zero_u%0d", u), {127'd0, zr}, 0);
    send(u, 128'h2);
    wait_done(u, zz, zr);
    chk($sformatf("dir_x2_z_u%0d", u), zz, Z2);
    send(u, 128'h0);
    wait_done(u, zz, zr);
    chk($sformatf("dir_x0_z_u%0d", u), zz, 128'h0);
    chk($sformatf("dir_x0_zero_u%0d", u), {127'd0, zr}, 1);
  endtask

  task automatic backpressure(input int u);
    logic [127:0] zz;
    logic zr;
    ordy[u] = 1'b0;
    send(u, 128'h2);
    wait_ov(u);
    @(posedge clk);
    #1;
    iv[u] = 1'b1;
    xv[u] = 128'h1234_5678_9abc_def0_0fed_cba9_8765_4321;
    repeat (20) begin
      @(negedge clk);
      chk($sformatf("bp_in_ready_u%0d", u), {127'd0, ir[u]}, 0);
      chk($sformatf("bp_out_valid_u%0d", u), {127'd0, ov[u]}, 1);
      chk($sformatf("bp_z_u%0d", u), zv[u], Z2);
    end
    @(posedge clk);
    #1;
    ordy[u] = 1'b1;
    @(negedge clk);
    chk($sformatf("bp_hs_ir_u%0d", u), {127'd0, ir[u]}, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk($sformatf("bp_after_ir_u%0d", u), {127'd0, ir[u]}, 1);
    chk($sformatf("bp_after_ov_u%0d", u), {127'd0, ov[u]}, 0);
    @(posedge clk);
    #1;
    iv[u] = 1'b0;
    xv[u] = rnd128();
    wait_done(u, zz, zr);
    chk($sformatf("bp_second_u%0d", u), zz,
        128'hc1a5_b3d0_6c93_1df3_4cf6_6e72_1d0e_b2a5 ^ 128'h0 ^
        ginv(128'h1234_5678_9abc_def0_0fed_cba9_8765_4321) ^
        128'hc1a5_b3d0_6c93_1df3_4cf6_6e72_1d0e_b2a5);
  endtask

  task automatic randoms(input int u, input int n);
    logic [127:0] zz, xr;
    logic zr;
    for (int i = 0; i < n; i++) begin
      xr = rnd128();
      if (xr == '0) xr = 128'h5;
      send(u, xr);
      wait_done(u, zz, zr);
    end
  endtask

  initial begin
    logic [127:0] one, zz;
    logic zr;
    int seen;
    for (int u = 0; u < 2; u++) begin
      iv[u] = 1'b0;
      ordy[u] = 1'b1;
      xv[u] = '0;
    end
    one = 128'h1;
    chk("model_mul_2_z2", gmul(128'h2, Z2), 128'h1);
    chk("model_reduce", gmul(one << 64, one << 64), 128'h87);
    chk("model_inv_1", ginv(128'h1), 128'h1);
    chk("model_inv_2", ginv(128'h2), Z2);
    chk("model_inv_0", ginv(128'h0), 128'h0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_checks();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    fork
      directed(0);
      directed(1);
    join
    fork
      backpressure(0);
      backpressure(1);
    join

    // Abort both units mid-operation (unit 1 near its end)
    fork
      send(0, 128'h2);
      send(1, 128'h2);
    join
    repeat (119) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    reset_checks();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (300) begin
      @(negedge clk);
      if (ov[0] || ov[1]) seen++;
    end
    chk("abort_quiet", 128'(seen), 128'd0);
    fork
      begin
        send(0, 128'h2);
        wait_done(0, zz, zr);
        chk("post_rst_z_u0", zz, Z2);
      end
      begin
        logic [127:0] z1;
        logic r1;
        send(1, 128'h2);
        wait_done(1, z1, r1);
        chk("post_rst_z_u1", z1, Z2);
      end
    join

    fork
      randoms(0, 30);
      randoms(1, 150);
    join

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
